// File: rtl/jtag_uart_pkg.sv
// Shared constants and FSM state type for the JTAG UART Avalon slave.
package jtag_uart_pkg;

  // Register map
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Register bit positions
  localparam int unsigned BIT_RE     = 0;
  localparam int unsigned BIT_WE     = 1;
  localparam int unsigned BIT_RI     = 8;
  localparam int unsigned BIT_WI     = 9;
  localparam int unsigned BIT_RVALID = 15;

  // Bus handshake: one wait state then acknowledge
  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so push is accepted even when full
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/jtag_uart_avalon_slave.sv
// JTAG UART style Avalon-MM slave: data/control registers over RX and TX byte FIFOs.
module jtag_uart_avalon_slave
  import jtag_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        av_chipselect,
  input  logic        av_address,
  input  logic        av_read_n,
  input  logic        av_write_n,
  input  logic [31:0] av_writedata,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic        av_irq,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic        host_rx_ready,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          re_q, re_d, we_q, we_d;
  logic          irq_q, irq_d;

  logic          access, is_rd, take;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count, tx_count, rx_nxt, tx_nxt;
  logic [15:0]   ravail, wspace;
  logic          ri, wi;
  logic          unused_wdata;

  assign unused_wdata = ^av_writedata[31:8];

  assign access = av_chipselect & (!av_read_n | !av_write_n);
  assign is_rd  = !av_read_n;
  assign take   = (state_q == S_IDLE) & access;

  assign rx_pop  = take & is_rd & (av_address == ADDR_DATA) & !rx_empty;
  assign tx_push = take & !is_rd & (av_address == ADDR_DATA) & (!tx_full | tx_pop);
  assign tx_pop  = host_tx_valid & host_tx_ready;

  // Ready also opens when full if an Avalon pop lands in the same cycle
  assign host_rx_ready = rst_n & (!rx_full | rx_pop);
  assign rx_push       = host_rx_valid & host_rx_ready;
  assign host_tx_valid = !tx_empty;

  assign ravail = 16'(rx_count - CW'(1));
  assign wspace = 16'(CW'(DEPTH) - tx_count);
  assign ri     = re_q & !rx_empty;
  assign wi     = we_q & (tx_count <= CW'(DEPTH / 4));

  assign rx_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);
  assign tx_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);

  assign av_waitrequest = !rst_n | take;
  assign av_readdata    = readdata_q;
  assign av_irq         = irq_q;

  sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i (host_rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .wdata_i (av_writedata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (host_tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Access FSM, register side effects and read data capture
  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    re_d       = re_q;
    we_d       = we_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_ACK;
          if (is_rd) begin
            readdata_d = '0;
            if (av_address == ADDR_DATA) begin
              if (!rx_empty) begin
                readdata_d[31:16]      = ravail;
                readdata_d[BIT_RVALID] = 1'b1;
                readdata_d[7:0]        = rx_head;
              end
            end else begin
              readdata_d[31:16]  = wspace;
              readdata_d[BIT_WI] = wi;
              readdata_d[BIT_RI] = ri;
              readdata_d[BIT_WE] = we_q;
              readdata_d[BIT_RE] = re_q;
            end
          end else if (av_address == ADDR_CTRL) begin
            re_d = av_writedata[BIT_RE];
            we_d = av_writedata[BIT_WE];
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Interrupt tracks the post-edge FIFO/enable state so it moves with the push/pop
    irq_d = (re_d & (rx_nxt != '0)) | (we_d & (tx_nxt <= CW'(DEPTH / 4)));
  end

  // State and register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      readdata_q <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_jtag_uart_avalon_slave.sv
// Directed plus randomized bench for jtag_uart_avalon_slave against a queue-based model.
module tb_jtag_uart_avalon_slave;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        av_chipselect, av_address, av_read_n, av_write_n;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest, av_irq;
  logic [7:0]  host_rx_data, host_tx_data;
  logic        host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_re, m_we;

  jtag_uart_avalon_slave #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .av_irq         (av_irq),
    .host_rx_data   (host_rx_data),
    .host_rx_valid  (host_rx_valid),
    .host_rx_ready  (host_rx_ready),
    .host_tx_data   (host_tx_data),
    .host_tx_valid  (host_tx_valid),
    .host_tx_ready  (host_tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_exp();
    if (rxq.size() == 0) return 32'h0;
    return {16'(rxq.size() - 1), 1'b1, 7'b0, rxq[0]};
  endfunction

  function automatic logic [31:0] ctrl_exp();
    bit ri, wi;
    ri = m_re && (rxq.size() != 0);
    wi = m_we && (txq.size() <= DEPTH / 4);
    return {16'(DEPTH - txq.size()), 6'b0, wi, ri, 6'b0, m_we, m_re};
  endfunction

  function automatic logic irq_exp();
    return (m_re && rxq.size() != 0) || (m_we && txq.size() <= DEPTH / 4);
  endfunction

  task automatic check_irq(input string tag);
    chk({tag, "_irq"}, {31'b0, av_irq}, {31'b0, irq_exp()});
  endtask

  // One complete Avalon access with host ports idle
  task automatic av_access(input logic addr, input logic rd, input logic [31:0] wd, input string tag);
    logic [31:0] exp;
    exp = 32'h0;
    @(negedge clk);
    av_chipselect = 1'b1; av_address = addr; av_read_n = !rd; av_write_n = rd; av_writedata = wd;
    #1 chk({tag, "_wait1"}, {31'b0, av_waitrequest}, 32'd1);
    if (rd) begin
      if (addr == 1'b0) begin
        exp = data_exp();
        if (rxq.size() != 0) void'(rxq.pop_front());
      end else begin
        exp = ctrl_exp();
      end
    end else if (addr == 1'b0) begin
      if (txq.size() < DEPTH) txq.push_back(wd[7:0]);
    end else begin
      m_re = wd[0];
      m_we = wd[1];
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_wait0"}, {31'b0, av_waitrequest}, 32'd0);
    if (rd) chk({tag, "_rdata"}, av_readdata, exp);
    check_irq(tag);
    av_chipselect = 1'b0; av_read_n = 1'b1; av_write_n = 1'b1;
  endtask

  task automatic host_push(input logic [7:0] d, input string tag);
    bit acc;
    @(negedge clk);
    host_rx_valid = 1'b1; host_rx_data = d;
    acc = (rxq.size() < DEPTH);
    #1 chk({tag, "_ready"}, {31'b0, host_rx_ready}, {31'b0, acc});
    @(posedge clk);
    @(negedge clk);
    if (acc) rxq.push_back(d);
    host_rx_valid = 1'b0;
    check_irq(tag);
  endtask

  task automatic tx_pop_cycle(input string tag);
    bit v;
    @(negedge clk);
    host_tx_ready = 1'b1;
    v = (txq.size() != 0);
    #1 chk({tag, "_valid"}, {31'b0, host_tx_valid}, {31'b0, v});
    if (v) chk({tag, "_data"}, {24'b0, host_tx_data}, {24'b0, txq[0]});
    @(posedge clk);
    @(negedge clk);
    if (v) void'(txq.pop_front());
    host_tx_ready = 1'b0;
    check_irq(tag);
  endtask

  initial begin
    logic [31:0] exp_held;
    exp_held = 32'h0;
    rst_n = 1'b0;
    av_chipselect = 1'b0; av_address = 1'b0; av_read_n = 1'b1; av_write_n = 1'b1;
    av_writedata = 32'h0; host_rx_data = 8'h0; host_rx_valid = 1'b0; host_tx_ready = 1'b0;
    m_re = 1'b0; m_we = 1'b0;

    // Reset state
    #1;
    chk("rst_wait", {31'b0, av_waitrequest}, 32'd1);
    chk("rst_rdata", av_readdata, 32'h0);
    chk("rst_irq", {31'b0, av_irq}, 32'd0);
    chk("rst_rxrdy", {31'b0, host_rx_ready}, 32'd0);
    chk("rst_txval", {31'b0, host_tx_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Control register after reset
    av_access(1'b1, 1'b1, 32'h0, "ctrl_reset");
    chk("ctrl_reset_abs", av_readdata, 32'h0040_0000);

    // Two bytes then an empty read
    host_push(8'h41, "p41");
    host_push(8'h42, "p42");
    av_access(1'b0, 1'b1, 32'h0, "rd41");
    chk("rd41_abs", av_readdata, 32'h0001_8041);
    av_access(1'b0, 1'b1, 32'h0, "rd42");
    chk("rd42_abs", av_readdata, 32'h0000_8042);
    av_access(1'b0, 1'b1, 32'h0, "rd_empty");

    // Read strobe held for four cycles: two accesses, two pops
    host_push(8'hA1, "ph1");
    host_push(8'hA2, "ph2");
    host_push(8'hA3, "ph3");
    @(negedge clk);
    av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0; av_write_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("held_wait%0d", i), {31'b0, av_waitrequest}, {31'b0, ((i % 2) == 0)});
      if ((i % 2) == 0) begin
        exp_held = data_exp();
        void'(rxq.pop_front());
      end else begin
        chk($sformatf("held_rdata%0d", i), av_readdata, exp_held);
      end
      @(negedge clk);
    end
    av_chipselect = 1'b0; av_read_n = 1'b1;
    av_access(1'b0, 1'b1, 32'h0, "held_rest");
    chk("held_rest_abs", av_readdata, 32'h0000_80A3);

    // Receive interrupt
    av_access(1'b1, 1'b0, 32'h1, "en_re");
    host_push(8'h55, "p55");
    chk("irq_on", {31'b0, av_irq}, 32'd1);
    av_access(1'b0, 1'b1, 32'h0, "rd55");
    chk("irq_off", {31'b0, av_irq}, 32'd0);

    // Fill TX, overflow drop, then drain in order
    for (int i = 0; i < DEPTH; i++) av_access(1'b0, 1'b0, $urandom, "txfill");
    av_access(1'b1, 1'b1, 32'h0, "tx_full_ctrl");
    av_access(1'b0, 1'b0, 32'h0000_00EE, "tx_drop");
    av_access(1'b1, 1'b1, 32'h0, "tx_full_ctrl2");
    av_access(1'b1, 1'b0, 32'h3, "en_we");
    for (int i = 0; i < DEPTH; i++) tx_pop_cycle("drain");
    tx_pop_cycle("drain_empty");

    // RX full with wrapped pointers; push and pop in the same cycle
    while (rxq.size() < DEPTH) host_push($urandom, "rxfill");
    host_push(8'hFF, "rx_full_drop");
    @(negedge clk);
    host_rx_valid = 1'b1; host_rx_data = 8'hC3;
    av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0; av_write_n = 1'b1;
    #1 chk("simul_ready", {31'b0, host_rx_ready}, 32'd1);
    exp_held = data_exp();
    void'(rxq.pop_front());
    rxq.push_back(8'hC3);
    @(posedge clk);
    @(negedge clk);
    chk("simul_rdata", av_readdata, exp_held);
    host_rx_valid = 1'b0; av_chipselect = 1'b0; av_read_n = 1'b1;
    #1 chk("simul_still_full", {31'b0, host_rx_ready}, 32'd0);
    while (rxq.size() != 0) av_access(1'b0, 1'b1, 32'h0, "rxdrain");

    // Randomized mix of operations
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: host_push($urandom, "r_push");
        1: av_access(1'b0, 1'b1, 32'h0, "r_rdat");
        2: av_access(1'b0, 1'b0, $urandom, "r_wdat");
        3: av_access(1'b1, 1'b1, 32'h0, "r_rctl");
        4: av_access(1'b1, 1'b0, $urandom, "r_wctl");
        default: tx_pop_cycle("r_txpop");
      endcase
    end

    // Reset during the acknowledge phase of a read
    while (rxq.size() != 0) av_access(1'b0, 1'b1, 32'h0, "pre_rst");
    host_push(8'h11, "rp1");
    host_push(8'h22, "rp2");
    host_push(8'h33, "rp3");
    @(negedge clk);
    av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0; av_write_n = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    rxq.delete(); txq.delete(); m_re = 1'b0; m_we = 1'b0;
    #1;
    chk("ack_rst_wait", {31'b0, av_waitrequest}, 32'd1);
    chk("ack_rst_rdata", av_readdata, 32'h0);
    chk("ack_rst_irq", {31'b0, av_irq}, 32'd0);
    chk("ack_rst_rxrdy", {31'b0, host_rx_ready}, 32'd0);
    chk("ack_rst_txval", {31'b0, host_tx_valid}, 32'd0);
    @(negedge clk);
    av_chipselect = 1'b0; av_read_n = 1'b1;
    @(negedge clk);
    #1 chk("ack_rst_wait2", {31'b0, av_waitrequest}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    av_access(1'b0, 1'b1, 32'h0, "post_rst_rd");
    av_access(1'b1, 1'b1, 32'h0, "post_rst_ctl");
    chk("post_rst_ctl_abs", av_readdata, 32'h0040_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_uart_avalon_slave.md
JTAG_UART_AVALON_SLAVE -- requirements
Module: jtag_uart_avalon_slave

Interface
REQ-001 SHALL have parameter DEPTH, 64, entries per FIFO (power of 2, 4..32768).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port av_chipselect  input  1  slave select.
REQ-005 SHALL have port av_address  input  1  0 = data register, 1 = control register.
REQ-006 SHALL have port av_read_n  input  1  read strobe, active-low.
REQ-007 SHALL have port av_write_n  input  1  write strobe, active-low.
REQ-008 SHALL have port av_writedata  input  32  write data.
REQ-009 SHALL have port av_readdata  output  32  read data, valid when waitrequest low in an access.
REQ-010 SHALL have port av_waitrequest  output  1  stall.
REQ-011 SHALL have port av_irq  output  1  level interrupt.
REQ-012 SHALL have ports host_rx_data/host_rx_valid  input  8/1, host_rx_ready  output  1: bytes into RX FIFO.
REQ-013 SHALL have ports host_tx_data/host_tx_valid  output  8/1, host_tx_ready  input  1: bytes out of TX FIFO.

Function
REQ-014 Access = av_chipselect & (!av_read_n | !av_write_n); both strobes low = read, write ignored.
REQ-015 Two-state FSM: S_IDLE, S_ACK; fixed one wait state per access.
REQ-016 S_IDLE: av_waitrequest = access (combinational); on access perform side effect, register av_readdata, go S_ACK.
REQ-017 S_ACK: av_waitrequest = 0, av_readdata held; go S_IDLE unconditionally; strobe still low re-enters as new access.
REQ-018 Side effects SHALL occur exactly once per access, on the S_IDLE->S_ACK edge.
REQ-019 Read addr 0: if RX non-empty, readdata = {RAVAIL[15:0], 1'b1 (bit15 RVALID), 7'b0, byte}, pop one; RAVAIL = count after pop.
REQ-020 Read addr 0 with RX empty: readdata = 32'h0, no pop.
REQ-021 Write addr 0: push writedata[7:0] to TX FIFO if not full; if full, byte silently dropped.
REQ-022 Read addr 1: readdata = {WSPACE[15:0], 6'b0, WI(bit9), RI(bit8), 6'b0, WE(bit1), RE(bit0)}; WSPACE = DEPTH - tx_count.
REQ-023 Write addr 1: RE <= writedata[0], WE <= writedata[1]; other bits ignored.
REQ-024 RI = RE & RX non-empty; WI = WE & (tx_count <= DEPTH/4); av_irq = RI | WI (registered).
REQ-025 host_rx_ready = !rx_full; push on valid & ready.
REQ-026 host_tx_valid = !tx_empty, host_tx_data = TX head (first-word fall-through); pop on valid & ready.
REQ-027 Simultaneous push and pop on one FIFO SHALL both complete, count unchanged; legal when full (pop frees) or empty (push only).
REQ-028 Counts SHALL be log2(DEPTH)+1 bits; pointers wrap modulo DEPTH without error.

Reset
REQ-029 rst_n low: FSM S_IDLE, both FIFOs empty, RE = WE = 0, av_readdata = 0, av_irq = 0, av_waitrequest = 1, host_rx_ready = 0, host_tx_valid = 0.
REQ-030 Reset mid-access SHALL abandon it with no pop/push; first access after release starts in S_IDLE.

Structure
REQ-031 Package jtag_uart_pkg SHALL hold register address constants, bit positions (RVALID, RE, WE, RI, WI) and the FSM enum.
REQ-032 One sub-module sync_fifo (8-bit, DEPTH, count output) SHALL be instantiated twice (RX, TX).

Verification
REQ-033 Host pushes 0x41,0x42; read addr 0 twice -> 0x00018041 then 0x00008042; third read -> 0x00000000.
REQ-034 Read addr 1 after reset, DEPTH=64 -> 0x00400000; 64 writes addr 0 -> WSPACE 0; 65th byte dropped; host_tx drains exactly 64 bytes in order.
REQ-035 Each access: waitrequest 1 for exactly the first cycle, 0 the second; read_n held low 4 cycles -> exactly 2 pops.
REQ-036 Write addr 1 = 0x1, host pushes 0x55 -> av_irq 1 next cycle; read addr 0 -> av_irq 0.
REQ-037 RX full (64), host push and Avalon pop same cycle -> count stays 64, ordering preserved across pointer wrap.
REQ-038 rst_n low during S_ACK with RX holding 3 bytes -> FIFO empty, readdata 0, waitrequest 1 until release.
